// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single D-cache port between loads and store-buffer drains; one access in flight, 1 idle cycle between.
// Define DCACHE_ARB_STARVE_GUARD_EN to force a pending drain through after STARVE_LIMIT load grants.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif

module dcache_port_arbiter #(
  parameter int WORD_SIZE        = `WORD_SIZE,
  parameter int WIDTH            = `ADDRESS_WIDTH,
  parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_req,
  input  logic [WIDTH-1:0]            ld_addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] ld_size,
  output logic                        ld_grant,
  output logic                        ld_done,
  output logic [WORD_SIZE-1:0]        ld_data,
  input  logic                        sb_wenable,
  input  logic [WIDTH-1:0]            sb_addr,
  input  logic [WORD_SIZE-1:0]        sb_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
  input  logic                        sb_full,
  output logic                        store_success,
  output logic                        c_req,
  output logic                        c_we,
  output logic [WIDTH-1:0]            c_addr,
  output logic [WORD_SIZE-1:0]        c_wdata,
  output logic [SIZE_WRITE_WIDTH-1:0] c_size,
  input  logic                        c_ready,
  input  logic [WORD_SIZE-1:0]        c_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            addr_q, addr_d;
  logic [WORD_SIZE-1:0]        wdata_q, wdata_d;
  logic [SIZE_WRITE_WIDTH-1:0] size_q, size_d;
  logic [WORD_SIZE-1:0]        ld_data_q, ld_data_d;
  logic                        ld_done_q, ld_done_d;
  logic                        store_success_q, store_success_d;
  logic                        store_win;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Only loads taken over a waiting drain count toward starvation.
  always_comb begin
    store_win    = sb_wenable && (sb_full || (starve_cnt_q == LIMIT) || !ld_req);
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (store_win) begin
        starve_cnt_d = 4'd0;
      end else if (ld_req && sb_wenable && (starve_cnt_q != LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= 4'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  logic [3:0] unused_starve_limit;
  assign unused_starve_limit = 4'(STARVE_LIMIT);

  always_comb begin
    store_win = sb_wenable && (sb_full || !ld_req);
  end
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    ld_data_d       = ld_data_q;
    ld_done_d       = 1'b0;
    store_success_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (store_win) begin
          state_d = STORE;
          addr_d  = sb_addr;
          wdata_d = sb_value;
          size_d  = sb_size;
        end else if (ld_req) begin
          state_d = LOAD;
          addr_d  = ld_addr;
          wdata_d = '0;
          size_d  = ld_size;
        end
      end
      LOAD: begin
        if (c_ready) begin
          state_d   = IDLE;
          ld_data_d = c_rdata;
          ld_done_d = 1'b1;
        end
      end
      STORE: begin
        if (c_ready) begin
          state_d         = IDLE;
          store_success_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      size_q          <= '0;
      ld_data_q       <= '0;
      ld_done_q       <= 1'b0;
      store_success_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      size_q          <= size_d;
      ld_data_q       <= ld_data_d;
      ld_done_q       <= ld_done_d;
      store_success_q <= store_success_d;
    end
  end

  assign ld_grant      = (state_q == LOAD);
  assign c_req         = (state_q != IDLE);
  assign c_we          = (state_q == STORE);
  assign c_addr        = addr_q;
  assign c_wdata       = wdata_q;
  assign c_size        = size_q;
  assign ld_data       = ld_data_q;
  assign ld_done       = ld_done_q;
  assign store_success = store_success_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: transaction-level model checked every cycle plus literal spot checks.
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif

module tb_dcache_port_arbiter;
  localparam int W = 32;
  localparam int A = 32;
  localparam int S = 2;
  localparam int LIMIT = 4;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [S-1:0] FULL = `FULL_WORD_SIZE;
  localparam logic [S-1:0] BYTE = `BYTE_SIZE;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_req, sb_wenable, sb_full, c_ready;
  logic [A-1:0] ld_addr, sb_addr;
  logic [S-1:0] ld_size, sb_size;
  logic [W-1:0] sb_value, c_rdata;
  logic         ld_grant, ld_done, store_success, c_req, c_we;
  logic [W-1:0] ld_data, c_wdata;
  logic [A-1:0] c_addr;
  logic [S-1:0] c_size;

  always #5 clk = ~clk;

  dcache_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_grant(ld_grant), .ld_done(ld_done), .ld_data(ld_data),
    .sb_wenable(sb_wenable), .sb_addr(sb_addr), .sb_value(sb_value), .sb_size(sb_size),
    .sb_full(sb_full), .store_success(store_success),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_ready(c_ready), .c_rdata(c_rdata)
  );

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got '%s', required '%s'", name, act, exp);
    end
  endtask

  // Transaction-level model: at most one access in flight, grant decided from requester state.
  typedef struct packed {
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    logic [S-1:0] size;
  } txn_t;

  bit           m_busy = 1'b0;
  txn_t         m_cur = '0;
  bit           m_ld_pulse = 1'b0;
  bit           m_st_pulse = 1'b0;
  logic [W-1:0] m_ld_data = '0;
  int           m_loads_over_drain = 0;
  string        m_log = "";

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_cur = '0; m_ld_pulse = 1'b0; m_st_pulse = 1'b0;
      m_ld_data = '0; m_loads_over_drain = 0;
    end else begin
      m_ld_pulse = 1'b0;
      m_st_pulse = 1'b0;
      if (m_busy) begin
        if (c_ready) begin
          m_busy = 1'b0;
          if (m_cur.we) m_st_pulse = 1'b1;
          else begin
            m_ld_pulse = 1'b1;
            m_ld_data  = c_rdata;
          end
        end
      end else if (sb_wenable && (sb_full || !ld_req || (GUARD && m_loads_over_drain >= LIMIT))) begin
        m_busy = 1'b1;
        m_cur  = '{1'b1, sb_addr, sb_value, sb_size};
        m_loads_over_drain = 0;
        m_log  = {m_log, "S"};
      end else if (ld_req) begin
        m_busy = 1'b1;
        m_cur  = '{1'b0, ld_addr, 32'h0, ld_size};
        if (sb_wenable && m_loads_over_drain < LIMIT) m_loads_over_drain++;
        m_log  = {m_log, "L"};
      end
    end
  end

  // Per-cycle compare, sampled 1 time unit after the active edge.
  bit    prev_req = 1'b0;
  string d_log = "";
  int    ld_pulses = 0, st_pulses = 0, req_cycles = 0;

  always begin
    @(posedge clk);
    #1;
    chk("c_req", {31'b0, c_req}, {31'b0, m_busy});
    chk("c_we", {31'b0, c_we}, {31'b0, m_busy && m_cur.we});
    chk("ld_grant", {31'b0, ld_grant}, {31'b0, m_busy && !m_cur.we});
    chk("ld_done", {31'b0, ld_done}, {31'b0, m_ld_pulse});
    chk("store_success", {31'b0, store_success}, {31'b0, m_st_pulse});
    chk("ld_data", ld_data, m_ld_data);
    chk("done_exclusive", {31'b0, ld_done & store_success}, 32'h0);
    if (m_busy) begin
      chk("c_addr", c_addr, m_cur.addr);
      chk("c_wdata", c_wdata, m_cur.wdata);
      chk("c_size", {30'b0, c_size}, {30'b0, m_cur.size});
    end
    if (c_req && !prev_req) begin
      if (c_we) d_log = {d_log, "S"};
      else      d_log = {d_log, "L"};
    end
    prev_req = c_req;
    if (ld_done) ld_pulses++;
    if (store_success) st_pulses++;
    if (c_req) req_cycles++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int    r0, l0, s0, b, mb;
  string exp3;

  initial begin
    rst = 1'b1;
    ld_req = 1'b0; ld_addr = '0; ld_size = '0;
    sb_wenable = 1'b0; sb_addr = '0; sb_value = '0; sb_size = '0; sb_full = 1'b0;
    c_ready = 1'b0; c_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_c_req", {31'b0, c_req}, 32'h0);
    chk("rst_ld_grant", {31'b0, ld_grant}, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_c_addr", c_addr, 32'h0);
    chk("rst_store_success", {31'b0, store_success}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Load only, c_ready in the first request cycle.
    r0 = req_cycles; l0 = ld_pulses; s0 = st_pulses;
    ld_req = 1'b1; ld_addr = 32'h100; ld_size = FULL;
    @(negedge clk);
    ld_req = 1'b0; ld_addr = 32'hFFFF_FFFF;
    c_ready = 1'b1; c_rdata = 32'hDEADBEEF;
    chk("t1_c_req", {31'b0, c_req}, 32'h1);
    chk("t1_c_we", {31'b0, c_we}, 32'h0);
    chk("t1_c_addr", c_addr, 32'h100);
    chk("t1_c_wdata", c_wdata, 32'h0);
    chk("t1_ld_grant", {31'b0, ld_grant}, 32'h1);
    @(negedge clk);
    c_ready = 1'b0; c_rdata = '0;
    chk("t1_ld_done", {31'b0, ld_done}, 32'h1);
    chk("t1_ld_data", ld_data, 32'hDEADBEEF);
    chk("t1_c_req_drop", {31'b0, c_req}, 32'h0);
    @(negedge clk);
    chk("t1_ld_done_once", {31'b0, ld_done}, 32'h0);
    chk("t1_req_cycles", req_cycles - r0, 32'd1);
    chk("t1_ld_pulses", ld_pulses - l0, 32'd1);
    chk("t1_st_pulses", st_pulses - s0, 32'd0);

    // Store drain with a 3-cycle request, head inputs changed during the stall.
    r0 = req_cycles; l0 = ld_pulses; s0 = st_pulses;
    sb_wenable = 1'b1; sb_addr = 32'h200; sb_value = 32'h12345678; sb_size = BYTE;
    @(negedge clk);
    sb_wenable = 1'b0; sb_addr = 32'hFFFF_0000; sb_value = '0; sb_size = FULL;
    for (int k = 0; k < 3; k++) begin
      chk("t2_c_we", {31'b0, c_we}, 32'h1);
      chk("t2_c_addr", c_addr, 32'h200);
      chk("t2_c_wdata", c_wdata, 32'h12345678);
      chk("t2_c_size", {30'b0, c_size}, {30'b0, BYTE});
      if (k == 2) c_ready = 1'b1;
      @(negedge clk);
    end
    c_ready = 1'b0;
    chk("t2_store_success", {31'b0, store_success}, 32'h1);
    chk("t2_c_req_drop", {31'b0, c_req}, 32'h0);
    @(negedge clk);
    chk("t2_store_success_once", {31'b0, store_success}, 32'h0);
    chk("t2_req_cycles", req_cycles - r0, 32'd3);
    chk("t2_st_pulses", st_pulses - s0, 32'd1);
    chk("t2_ld_pulses", ld_pulses - l0, 32'd0);

    // Loads and drains both held: starvation guard decides the pattern.
    b = d_log.len(); mb = m_log.len();
    ld_req = 1'b1; ld_addr = 32'h500; ld_size = FULL;
    sb_wenable = 1'b1; sb_addr = 32'h400; sb_value = 32'hA5A5A5A5; sb_size = FULL;
    c_ready = 1'b1; c_rdata = 32'h11110000;
    for (int i = 0; i < 60 && d_log.len() < b + 10; i++) @(negedge clk);
    ld_req = 1'b0; sb_wenable = 1'b0;
    if (GUARD) exp3 = "LLLLSLLLLS";
    else       exp3 = "LLLLLLLLLL";
    chk_s("t3_dut_grants", d_log.substr(b, b + 9), exp3);
    chk_s("t3_model_grants", m_log.substr(mb, mb + 9), exp3);
    repeat (2) @(negedge clk);
    c_ready = 1'b0;
    @(negedge clk);

    // Full store buffer wins over a simultaneous load.
    b = d_log.len();
    ld_req = 1'b1; ld_addr = 32'h600; ld_size = FULL;
    sb_wenable = 1'b1; sb_full = 1'b1; sb_addr = 32'h700; sb_value = 32'hCAFEF00D; sb_size = BYTE;
    @(negedge clk);
    chk("t4_first_is_store", {31'b0, c_we}, 32'h1);
    chk("t4_store_addr", c_addr, 32'h700);
    sb_wenable = 1'b0; sb_full = 1'b0; c_ready = 1'b1; c_rdata = 32'h0BADF00D;
    for (int i = 0; i < 20 && d_log.len() < b + 2; i++) @(negedge clk);
    ld_req = 1'b0;
    chk_s("t4_grants", d_log.substr(b, b + 1), "SL");
    repeat (2) @(negedge clk);
    c_ready = 1'b0;
    chk("t4_ld_data", ld_data, 32'h0BADF00D);
    @(negedge clk);

    // Asynchronous reset in the middle of a stalled store.
    sb_wenable = 1'b1; sb_addr = 32'h800; sb_value = 32'h55AA55AA; sb_size = BYTE;
    @(negedge clk);
    sb_wenable = 1'b0;
    chk("t5_c_req_before", {31'b0, c_req}, 32'h1);
    chk("t5_c_we_before", {31'b0, c_we}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    c_ready = 1'b1;
    #1;
    chk("t5_c_req_rst", {31'b0, c_req}, 32'h0);
    chk("t5_c_we_rst", {31'b0, c_we}, 32'h0);
    chk("t5_ld_grant_rst", {31'b0, ld_grant}, 32'h0);
    chk("t5_store_success_rst", {31'b0, store_success}, 32'h0);
    chk("t5_c_addr_rst", c_addr, 32'h0);
    chk("t5_ld_data_rst", ld_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = st_pulses;
    repeat (4) @(negedge clk);
    c_ready = 1'b0;
    chk("t5_no_pulse_after_rst", st_pulses - s0, 32'd0);
    chk("t5_idle_after_rst", {31'b0, c_req}, 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
